if_id_reg: RTL

IF/ID pipeline register of the five-stage MIPS pipeline. It sits directly downstream of the fetch stage and captures the fetched instruction, its PC, and PC+4 each cycle for the decode stage. It holds its contents on a load-use stall and inserts a bubble on a control-hazard flush. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/if_id_predecode.sv | 33 +++
 rtl/if_id_reg.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the five-stage MIPS pipeline: reset PC, NOP encoding,
// and the opcode/funct values needed to classify control-flow instructions.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_JAL    = 6'd3;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_BLEZ   = 6'd6;
  localparam logic [5:0] OP_BGTZ   = 6'd7;

  localparam logic [5:0] FN_JR     = 6'd8;
  localparam logic [5:0] FN_JALR   = 6'd9;

endpackage

// File: rtl/if_id_predecode.sv
// Combinational early classification of a fetched instruction (branch, jump,
// jump-register) plus the J-format target; used only with IF_ID_PREDECODE_EN.
module if_id_predecode
  import pipeline_pkg::*;
(
  input  logic [3:0]  pc_plus_4_hi,
  input  logic [31:0] ir,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_jr,
  output logic [31:0] jump_target
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  always_comb begin
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    is_jr       = 1'b0;
    jump_target = {pc_plus_4_hi, ir[25:0], 2'b00};
    unique case (opcode)
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
      OP_J, OP_JAL:                                is_jump   = 1'b1;
      OP_RTYPE: is_jr = (funct == FN_JR) || (funct == FN_JALR);
      default: ;
    endcase
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold, flush bubble and saturating event
// counters. Define IF_ID_PREDECODE_EN to add registered predecode outputs.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IF_PC,
  input  logic [31:0]      IF_PC_plus_4,
  input  logic [31:0]      IF_IR,
  input  logic             stall,
  input  logic             flush,
  output logic [31:0]      ID_PC,
  output logic [31:0]      ID_PC_plus_4,
  output logic [31:0]      ID_IR,
  output logic             ID_valid,
`ifdef IF_ID_PREDECODE_EN
  output logic             ID_is_branch,
  output logic             ID_is_jump,
  output logic             ID_is_jr,
  output logic [31:0]      ID_jump_target,
`endif
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [31:0]      pc_p1;
  logic [31:0]      pc4_p1;
  logic [31:0]      ir_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // IF -> ID boundary; flush kills the slot but keeps its PC for debug
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_p1       <= RESET_PC;
      pc4_p1      <= RESET_PC + 32'd4;
      ir_p1       <= NOP_INSTR;
      vld_p1      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (flush) begin
      pc_p1       <= IF_PC;
      pc4_p1      <= IF_PC_plus_4;
      ir_p1       <= NOP_INSTR;
      vld_p1      <= 1'b0;
      flush_cnt_q <= sat_inc(flush_cnt_q);
    end else if (stall) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end else begin
      pc_p1  <= IF_PC;
      pc4_p1 <= IF_PC_plus_4;
      ir_p1  <= IF_IR;
      vld_p1 <= 1'b1;
    end
  end

  assign ID_PC        = pc_p1;
  assign ID_PC_plus_4 = pc4_p1;
  assign ID_IR        = ir_p1;
  assign ID_valid     = vld_p1;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

`ifdef IF_ID_PREDECODE_EN
  logic        is_branch_p0;
  logic        is_jump_p0;
  logic        is_jr_p0;
  logic [31:0] jump_target_p0;
  logic        is_branch_p1;
  logic        is_jump_p1;
  logic        is_jr_p1;
  logic [31:0] jump_target_p1;

  if_id_predecode u_predecode (
    .pc_plus_4_hi (IF_PC_plus_4[31:28]),
    .ir           (IF_IR),
    .is_branch    (is_branch_p0),
    .is_jump      (is_jump_p0),
    .is_jr        (is_jr_p0),
    .jump_target  (jump_target_p0)
  );

  // predecode travels with the payload: cleared on reset/flush, held on stall
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      is_branch_p1   <= 1'b0;
      is_jump_p1     <= 1'b0;
      is_jr_p1       <= 1'b0;
      jump_target_p1 <= '0;
    end else if (!stall) begin
      is_branch_p1   <= is_branch_p0;
      is_jump_p1     <= is_jump_p0;
      is_jr_p1       <= is_jr_p0;
      jump_target_p1 <= jump_target_p0;
    end
  end

  assign ID_is_branch   = is_branch_p1;
  assign ID_is_jump     = is_jump_p1;
  assign ID_is_jr       = is_jr_p1;
  assign ID_jump_target = jump_target_p1;
`endif

endmodule
